// File: rtl/aes_128.sv
// Fully pipelined AES-128 encryption core, no handshake and no reset on the datapath.
// Latency: ciphertext appears on AES_output 20 edges after the edge that samples state/key.
// Backpressure: none; the pipeline advances every cycle and cannot be stalled.
module aes_128 (
    input  logic         clk,
    input  logic [127:0] state,
    input  logic [127:0] key,
    output logic [127:0] AES_output
);

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    // Multiplicative inverse as b^254, then the affine transform.
    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = b;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gmul(sq, sq);
            inv = gmul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] sub_shift(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(4*c+r) -: 8] = sbox(s[127-8*(4*((c+r)%4)+r) -: 8]);
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] mix(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
            o[119-32*c -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
            o[111-32*c -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
            o[103-32*c -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
        return o;
    endfunction

    function automatic logic [7:0] rcon(input int rnd);
        logic [7:0] rc;
        rc = 8'h01;
        for (int i = 1; i < rnd; i++) rc = xt(rc);
        return rc;
    endfunction

    function automatic logic [127:0] key_next(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] t, w0, w1, w2, w3;
        t  = {sbox(k[23:16]) ^ rc, sbox(k[15:8]), sbox(k[7:0]), sbox(k[31:24])};
        w0 = k[127:96] ^ t;
        w1 = k[95:64] ^ w0;
        w2 = k[63:32] ^ w1;
        w3 = k[31:0] ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    // Each round is split into SubBytes/ShiftRows and MixColumns/AddRoundKey stages.
    logic [127:0] st_q  [0:20];
    logic [127:0] st_d  [0:20];
    logic [127:0] key_q [0:19];
    logic [127:0] key_d [0:19];

    always_comb begin
        st_d[0]  = state ^ key;
        key_d[0] = key;
        for (int r = 1; r <= 10; r++) begin
            st_d[2*r-1]  = sub_shift(st_q[2*r-2]);
            key_d[2*r-1] = key_next(key_q[2*r-2], rcon(r));
        end
        for (int r = 1; r <= 9; r++) begin
            st_d[2*r]  = mix(st_q[2*r-1]) ^ key_q[2*r-1];
            key_d[2*r] = key_q[2*r-1];
        end
        st_d[20] = st_q[19] ^ key_q[19];
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i <= 20; i++) st_q[i] <= st_d[i];
        for (int i = 0; i <= 19; i++) key_q[i] <= key_d[i];
    end

    assign AES_output = st_q[20];

endmodule

// File: rtl/aes_128_stream.sv
// Valid/ready wrapper around the unstallable aes_128 core; optional tag lane via AES128_STREAM_TAG_EN.
// Latency: result visible on out_valid LATENCY cycles after the input handshake (always via the FIFO).
// Backpressure: credits bound in-flight + queued blocks to FIFO_DEPTH, so core results are never dropped.
module aes_128_stream #(
    parameter int LATENCY    = 21,
    parameter int FIFO_DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic [127:0] in_key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
`ifdef AES128_STREAM_TAG_EN
    ,
    input  logic [7:0]   in_tag,
    output logic [7:0]   out_tag
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;

    logic           acc;
    logic           pop;
    logic           empty;
    logic           wr_en;
    logic [127:0]   core_out;
    logic [LATENCY:1] vld_q;
    logic [PW-1:0]  cred_q, cred_d;
    logic [PW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [127:0]   fifo_q [FIFO_DEPTH];

    aes_128 u_core (
        .clk        (clk),
        .state      (in_data),
        .key        (in_key),
        .AES_output (core_out)
    );

    // Bit 0 of the delay line is the handshake itself; the core lands a block
    // LATENCY-1 edges after sampling, so the FIFO write falls on edge N+LATENCY.
    assign acc       = in_valid && in_ready;
    assign wr_en     = vld_q[LATENCY];
    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign out_valid = !empty;
    assign pop       = out_valid && out_ready;
    assign in_ready  = (cred_q != '0);
    assign busy      = (|vld_q) || !empty;
    assign out_data  = empty ? '0 : fifo_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        cred_d = cred_q;
        if (acc && !pop)      cred_d = cred_q - PW'(1);
        else if (pop && !acc) cred_d = cred_q + PW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q    <= '0;
            cred_q   <= PW'(FIFO_DEPTH);
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            vld_q  <= {vld_q[LATENCY-1:1], acc};
            cred_q <= cred_d;
            if (wr_en) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)   rd_ptr_q <= rd_ptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) fifo_q[wr_ptr_q[AW-1:0]] <= core_out;
    end

`ifdef AES128_STREAM_TAG_EN
    logic [7:0] tag_q  [1:LATENCY];
    logic [7:0] tfifo_q [FIFO_DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i <= LATENCY; i++) tag_q[i] <= 8'h00;
        end else begin
            tag_q[1] <= in_tag;
            for (int i = 2; i <= LATENCY; i++) tag_q[i] <= tag_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) tfifo_q[wr_ptr_q[AW-1:0]] <= tag_q[LATENCY];
    end

    assign out_tag = empty ? 8'h00 : tfifo_q[rd_ptr_q[AW-1:0]];
`endif

endmodule

// File: tb/tb_aes_128_stream.sv
// Randomised and directed bench for aes_128_stream against a queue-based stream model
// and a byte-oriented AES-128 reference.
module tb_aes_128_stream;

    localparam int LAT   = 21;
    localparam int DEPTH = 4;

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C2_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] C2_PT  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] C2_CT  = 128'h3925841d02dc09fbdc118597196a0b32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [127:0] in_data = '0;
    logic [127:0] in_key = '0;
    logic         in_ready;
    logic         out_valid;
    logic [127:0] out_data;
    logic         busy;
`ifdef AES128_STREAM_TAG_EN
    logic [7:0]   in_tag = 8'h00;
    logic [7:0]   out_tag;
`endif

    aes_128_stream #(.LATENCY(LAT), .FIFO_DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_key    (in_key),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
`ifdef AES128_STREAM_TAG_EN
        ,
        .in_tag    (in_tag),
        .out_tag   (out_tag)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] ct;
        logic [7:0]   tg;
        int           rdy;
    } ent_t;

    ent_t         exp_q[$];
    logic [127:0] pop_dat[$];
    logic [7:0]   pop_tag[$];
    int           pop_cyc[$];
    logic [7:0]   sbox_t [256];
    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int n_acc = 0;
    int n_pop = 0;

    task automatic chk_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // S-box generated by walking the multiplicative group with generator 3.
    task automatic build_sbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b00};
            q = q ^ {q[3:0], 4'h0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            sbox_t[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sbox_t[0] = 8'h63;
    endtask

    function automatic logic [127:0] aes_ref(input logic [127:0] k, input logic [127:0] pt);
        logic [7:0]   w [176];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   tmp [4];
        logic [7:0]   a [4];
        logic [7:0]   rc;
        logic [127:0] res;
        rc = 8'h01;
        for (int i = 0; i < 16; i++) w[i] = k[127-8*i -: 8];
        for (int i = 4; i < 44; i++) begin
            for (int j = 0; j < 4; j++) tmp[j] = w[4*(i-1)+j];
            if (i % 4 == 0) begin
                tmp = '{sbox_t[w[4*i-3]] ^ rc, sbox_t[w[4*i-2]], sbox_t[w[4*i-1]], sbox_t[w[4*i-4]]};
                rc = xt(rc);
            end
            for (int j = 0; j < 4; j++) w[4*i+j] = w[4*(i-4)+j] ^ tmp[j];
        end
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int i = 0; i < 16; i++) s[i] = sbox_t[s[i]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) t[r+4*c] = s[r+4*((c+r)%4)];
            s = t;
            if (rnd < 10) begin
                for (int c = 0; c < 4; c++) begin
                    for (int r = 0; r < 4; r++) a[r] = s[4*c+r];
                    for (int r = 0; r < 4; r++)
                        s[4*c+r] = xt(a[r]) ^ xt(a[(r+1)%4]) ^ a[(r+1)%4] ^ a[(r+2)%4] ^ a[(r+3)%4];
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[16*rnd+i];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // One clock: compare outputs with the model, drive, advance the model past the edge.
    task automatic step(input logic v, input logic [127:0] d, input logic [127:0] k,
                        input logic [7:0] tg, input logic ordy);
        logic         m_rdy, m_ov;
        logic [127:0] m_dat;
        logic [7:0]   m_tag;
        ent_t         e;
        m_rdy = (exp_q.size() < DEPTH);
        m_ov  = (exp_q.size() > 0) && (exp_q[0].rdy <= cyc);
        m_dat = m_ov ? exp_q[0].ct : '0;
        m_tag = m_ov ? exp_q[0].tg : 8'h00;
        chk_eq("in_ready", 128'(in_ready), 128'(m_rdy));
        chk_eq("out_valid", 128'(out_valid), 128'(m_ov));
        chk_eq("busy", 128'(busy), 128'(exp_q.size() > 0));
        chk_eq("out_data", out_data, m_dat);
`ifdef AES128_STREAM_TAG_EN
        chk_eq("out_tag", 128'(out_tag), 128'(m_tag));
        if (out_valid && ordy) pop_tag.push_back(out_tag);
        in_tag = tg;
`endif
        if (out_valid && ordy) begin
            pop_dat.push_back(out_data);
            pop_cyc.push_back(cyc);
            n_pop++;
        end
        if (v && in_ready) n_acc++;
        in_valid  = v;
        in_data   = d;
        in_key    = k;
        out_ready = ordy;
        @(posedge clk);
        cyc++;
        if (m_ov && ordy) void'(exp_q.pop_front());
        if (v && m_rdy) begin
            e.ct  = aes_ref(k, d);
            e.tg  = tg;
            e.rdy = cyc + LAT;
            exp_q.push_back(e);
        end
        #1;
    endtask

    task automatic idle(input int n, input logic ordy);
        repeat (n) step(1'b0, rnd128(), rnd128(), 8'h00, ordy);
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        rst_n     = 1'b0;
        #1;
        chk_eq("rst_out_valid", 128'(out_valid), 128'(0));
        chk_eq("rst_busy", 128'(busy), 128'(0));
        chk_eq("rst_in_ready", 128'(in_ready), 128'(1));
        chk_eq("rst_out_data", out_data, '0);
        exp_q.delete();
        @(posedge clk);
        cyc++;
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        build_sbox();
        repeat (3) @(posedge clk);
        #1;
        chk_eq("reset_in_ready", 128'(in_ready), 128'(1));
        chk_eq("reset_out_valid", 128'(out_valid), 128'(0));
        chk_eq("reset_busy", 128'(busy), 128'(0));
        chk_eq("reset_out_data", out_data, '0);
`ifdef AES128_STREAM_TAG_EN
        chk_eq("reset_out_tag", 128'(out_tag), 128'(0));
`endif
        rst_n = 1'b1;

        // Single FIPS-197 C.1 block: out_valid must rise exactly LAT cycles after accept.
        step(1'b1, C1_PT, C1_KEY, 8'h11, 1'b0);
        idle(LAT - 1, 1'b0);
        chk_eq("c1_early", 128'(out_valid), 128'(0));
        idle(1, 1'b0);
        chk_eq("c1_valid_at_lat", 128'(out_valid), 128'(1));
        chk_eq("c1_data", out_data, C1_CT);
        idle(3, 1'b1);

        // Back-to-back burst of two known vectors with out_ready held high.
        pop_dat.delete();
        pop_cyc.delete();
        step(1'b1, C1_PT, C1_KEY, 8'h21, 1'b1);
        step(1'b1, C2_PT, C2_KEY, 8'h22, 1'b1);
        idle(LAT + 3, 1'b1);
        chk_eq("burst_count", 128'(pop_dat.size()), 128'(2));
        if (pop_dat.size() >= 2) begin
            chk_eq("burst_first", pop_dat[0], C1_CT);
            chk_eq("burst_second", pop_dat[1], C2_CT);
            chk_eq("burst_gap", 128'(pop_cyc[1] - pop_cyc[0]), 128'(1));
        end

        // Backpressure: six offers with out_ready low, only DEPTH accepted.
        n_acc = 0;
        repeat (6) step(1'b1, rnd128(), rnd128(), 8'($urandom), 1'b0);
        chk_eq("bp_accepts", 128'(n_acc), 128'(DEPTH));
        chk_eq("bp_in_ready_low", 128'(in_ready), 128'(0));
        idle(LAT + 1, 1'b0);
        chk_eq("full_in_ready", 128'(in_ready), 128'(0));
        n_pop = 0;
        step(1'b1, rnd128(), rnd128(), 8'h5a, 1'b1);
        chk_eq("full_no_accept", 128'(n_acc), 128'(DEPTH));
        chk_eq("after_pop_in_ready", 128'(in_ready), 128'(1));
        chk_eq("after_pop_valid", 128'(out_valid), 128'(1));
        idle(6, 1'b1);
        chk_eq("bp_pops", 128'(n_pop), 128'(DEPTH));

        // Reset with one block queued and three in flight.
        step(1'b1, rnd128(), rnd128(), 8'h31, 1'b0);
        idle(LAT, 1'b0);
        repeat (3) step(1'b1, rnd128(), rnd128(), 8'h32, 1'b0);
        chk_eq("pre_reset_busy", 128'(busy), 128'(1));
        do_reset();
        chk_eq("post_reset_in_ready", 128'(in_ready), 128'(1));
        repeat (LAT + 2) step(1'b0, rnd128(), rnd128(), 8'h00, 1'($urandom_range(0, 1)));

`ifdef AES128_STREAM_TAG_EN
        // Tag alignment under out_ready toggling 1,0,1.
        pop_tag.delete();
        step(1'b1, rnd128(), rnd128(), 8'hA1, 1'b1);
        step(1'b1, rnd128(), rnd128(), 8'hB2, 1'b0);
        step(1'b1, rnd128(), rnd128(), 8'hC3, 1'b1);
        for (int i = 0; i < LAT + 8; i++) step(1'b0, '0, '0, 8'h00, 1'((i % 3) != 1));
        chk_eq("tag_count", 128'(pop_tag.size()), 128'(3));
        if (pop_tag.size() >= 3) begin
            chk_eq("tag_a1", 128'(pop_tag[0]), 128'(8'hA1));
            chk_eq("tag_b2", 128'(pop_tag[1]), 128'(8'hB2));
            chk_eq("tag_c3", 128'(pop_tag[2]), 128'(8'hC3));
        end
`endif

        // Randomised traffic with random backpressure.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 3) != 0), rnd128(), rnd128(), 8'($urandom),
                 1'($urandom_range(0, 2) != 0));
        end
        idle(LAT + DEPTH + 4, 1'b1);
        chk_eq("end_busy", 128'(busy), 128'(0));
        chk_eq("end_in_ready", 128'(in_ready), 128'(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
